dec_scan_ctrl: RTL and testbench

Upstream driver for the 2-to-4 decoder (inputs A, B, E). It cycles the select lines through slots 0..3 at a programmable rate to time-multiplex four loads, such as 4-digit display enables. It inserts a blanking interval, with E low, at every slot change to prevent ghosting, and gates E per slot with a mask. It pulses frame_done once per full 4-slot sweep.

---
 rtl/dec_scan_ctrl_pkg.sv | 15 +
 rtl/dec_scan_ctrl_scan_prescaler.sv | 30 +++
 rtl/dec_scan_ctrl.sv | 111 +++++++++++
 tb/tb_dec_scan_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/dec_scan_ctrl_pkg.sv
// Shared types and widths for the decoder scan controller.
package dec_scan_ctrl_pkg;

    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned BLANK_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_e;

    typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/dec_scan_ctrl_scan_prescaler.sv
// Dwell prescaler: clearable up-counter with advance enable and terminal-count flag.
module scan_prescaler #(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned DIV_MAX   = 49999
) (
    input  logic clk,
    input  logic clr_i,
    input  logic adv_i,
    output logic tc_o
);

    localparam logic [DIV_WIDTH-1:0] MAX_C = DIV_WIDTH'(DIV_MAX);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (adv_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == MAX_C);

endmodule

// File: rtl/dec_scan_ctrl.sv
// Scans a 2-to-4 decoder through slots 0..3 with per-slot blanking and E masking.
module dec_scan_ctrl
    import dec_scan_ctrl_pkg::*;
#(
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned DIV_MAX      = 49999,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       hold,
    input  logic [3:0] mask,
    output logic       A,
    output logic       B,
    output logic       E,
    output logic       frame_done
);

    localparam logic [BLANK_W-1:0] BLANK_LAST =
        BLANK_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam state_e ENTRY_S = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;

    state_e               state_q, state_d;
    slot_t                slot_q, slot_d;
    logic [BLANK_W-1:0]   blank_q, blank_d;
    logic                 a_q, b_q, e_q, fd_q;
    logic                 e_d, fd_d;
    logic                 tc, step, presc_clr;

    scan_prescaler #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_MAX   (DIV_MAX)
    ) u_presc (
        .clk   (clk),
        .clr_i (presc_clr),
        .adv_i (~hold),
        .tc_o  (tc)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        blank_d = blank_q;
        fd_d    = 1'b0;
        step    = (state_q == S_DRIVE) && tc && !hold;
        if (!en) begin
            state_d = S_IDLE;
            slot_d  = '0;
            blank_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = ENTRY_S;
                    slot_d  = '0;
                    blank_d = '0;
                end
                S_BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        state_d = S_DRIVE;
                        blank_d = '0;
                    end else begin
                        blank_d = blank_q + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (step) begin
                        slot_d  = slot_q + 1'b1;
                        state_d = ENTRY_S;
                        blank_d = '0;
                        fd_d    = (slot_q == '1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    slot_d  = '0;
                    blank_d = '0;
                end
            endcase
        end
        // Outputs are registered from next-state so E and {A,B} move on the same edge.
        e_d       = (state_d == S_DRIVE) && mask[slot_d];
        presc_clr = rst || (state_q != S_DRIVE) || (state_d != S_DRIVE) || step;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            blank_q <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            e_q     <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            blank_q <= blank_d;
            a_q     <= slot_d[1];
            b_q     <= slot_d[0];
            e_q     <= e_d;
            fd_q    <= fd_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign E          = e_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Self-checking bench for dec_scan_ctrl with DIV_MAX=3, BLANK_CYCLES=2 (6-cycle slot, 24-cycle frame).
module tb_dec_scan_ctrl;

    typedef struct {
        int         id;
        logic       rst;
        logic       en;
        logic       hold;
        logic [3:0] mask;
        logic       a;
        logic       b;
        logic       e;
        logic       fd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] mask = 4'h0;
    logic       A, B, E, frame_done;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    dec_scan_ctrl #(
        .DIV_WIDTH    (16),
        .DIV_MAX      (3),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .hold       (hold),
        .mask       (mask),
        .A          (A),
        .B          (B),
        .E          (E),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected outputs k edges after the enabling edge of a run (k=0 is the IDLE->BLANK edge).
    function automatic vec_t mk_run(int k, logic [3:0] m, logic h);
        vec_t v;
        int   slot;
        int   ph;
        slot   = (k / 6) % 4;
        ph     = k % 6;
        v.id   = 0;
        v.rst  = 1'b0;
        v.en   = 1'b1;
        v.hold = h;
        v.mask = m;
        v.a    = slot[1];
        v.b    = slot[0];
        v.e    = (ph >= 2) && m[slot];
        v.fd   = (k > 0) && (k % 24 == 0);
        return v;
    endfunction

    function automatic vec_t mk_zero(logic r, logic e_in, logic h);
        vec_t v;
        v.id   = 0;
        v.rst  = r;
        v.en   = e_in;
        v.hold = h;
        v.mask = 4'hF;
        v.a    = 1'b0;
        v.b    = 1'b0;
        v.e    = 1'b0;
        v.fd   = 1'b0;
        return v;
    endfunction

    // Scoreboard checker: one expectation per clock edge, sampled 1 time unit after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            vec_t x;
            x = exp_q.pop_front();
            n_cmp++;
            if ({A, B, E, frame_done} !== {x.a, x.b, x.e, x.fd}) begin
                n_bad++;
                $display("FAIL vec%0d: {A,B,E,frame_done} got %b%b%b%b required %b%b%b%b",
                         x.id, A, B, E, frame_done, x.a, x.b, x.e, x.fd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k_eff;

        // Reset: held with en=1, outputs stay low.
        vecs.push_back(mk_zero(1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk_zero(1'b1, 1'b1, 1'b0));
        // Free run, full mask, then mask switched to 0101 mid-run.
        for (int k = 0; k < 50; k++) vecs.push_back(mk_run(k, 4'hF, 1'b0));
        for (int k = 50; k < 74; k++) vecs.push_back(mk_run(k, 4'h5, 1'b0));
        // Hold for 5 cycles in slot 1 DRIVE, then hold asserted during slot 2 BLANK (ignored).
        vecs.push_back(mk_zero(1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 31; k++) begin
            k_eff = (k <= 8) ? k : (k <= 13) ? 8 : k - 5;
            vecs.push_back(mk_run(k_eff, 4'hF,
                ((k >= 9 && k <= 13) || k == 18 || k == 19) ? 1'b1 : 1'b0));
        end
        // Disable mid-DRIVE of slot 2 (with hold high: en wins), then re-enable.
        vecs.push_back(mk_zero(1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 15; k++) vecs.push_back(mk_run(k, 4'hF, 1'b0));
        vecs.push_back(mk_zero(1'b0, 1'b0, 1'b1));
        vecs.push_back(mk_zero(1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 14; k++) vecs.push_back(mk_run(k, 4'hF, 1'b0));
        // Reset during BLANK of slot 3, then restart through a full frame.
        vecs.push_back(mk_zero(1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 19; k++) vecs.push_back(mk_run(k, 4'hF, 1'b0));
        vecs.push_back(mk_zero(1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 26; k++) vecs.push_back(mk_run(k, 4'hF, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v    = vecs[i];
            v.id = i;
            @(negedge clk);
            rst  = v.rst;
            en   = v.en;
            hold = v.hold;
            mask = v.mask;
            exp_q.push_back(v);
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
